// File: rtl/mshr_refill_controller_if.sv
// rtl/mshr_refill_controller_if.sv - MSHR refill controller request, memory, fill and writeback bundle
interface mshr_refill_controller_if #(
  parameter int LINE_WORDS = 4,
  parameter int ROB_IDX_W  = 5
);
  logic                    flush_i;
  logic                    repair_req_i;
  logic [31:0]             repair_req_addr_i;
  logic [31:0]             repair_req_data_i;
  logic [ROB_IDX_W-1:0]    repair_req_rob_idx_i;
  logic                    repair_is_store_i;
  logic                    repair_ack_o;
  logic                    repair_complete_o;
  logic                    mem_req_o;
  logic [31:0]             mem_addr_o;
  logic                    mem_gnt_i;
  logic                    mem_rvalid_i;
  logic [31:0]             mem_rdata_i;
  logic                    fill_en_o;
  logic [31:0]             fill_addr_o;
  logic [32*LINE_WORDS-1:0] fill_data_o;
  logic                    fill_dirty_o;
  logic                    wb_valid_o;
  logic [ROB_IDX_W-1:0]    wb_rob_idx_o;
  logic [31:0]             wb_data_o;

  modport slave (
    input  flush_i, repair_req_i, repair_req_addr_i, repair_req_data_i,
           repair_req_rob_idx_i, repair_is_store_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output repair_ack_o, repair_complete_o, mem_req_o, mem_addr_o, fill_en_o,
           fill_addr_o, fill_data_o, fill_dirty_o, wb_valid_o, wb_rob_idx_o, wb_data_o
  );

  modport master (
    output flush_i, repair_req_i, repair_req_addr_i, repair_req_data_i,
           repair_req_rob_idx_i, repair_is_store_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  repair_ack_o, repair_complete_o, mem_req_o, mem_addr_o, fill_en_o,
           fill_addr_o, fill_data_o, fill_dirty_o, wb_valid_o, wb_rob_idx_o, wb_data_o
  );
endinterface

// File: rtl/mshr_refill_controller.sv
// rtl/mshr_refill_controller.sv - fetches a missed line word by word, merges store data, fills cache, returns load word
module mshr_refill_controller #(
  parameter int LINE_WORDS = 4,
  parameter int ROB_IDX_W  = 5
) (
  input logic                     clk_i,
  input logic                     rst_i,
  mshr_refill_controller_if.slave bus
);
  localparam int WI_W = $clog2(LINE_WORDS);
  localparam int OFF  = WI_W + 2;
  localparam logic [WI_W-1:0] LAST_BEAT = WI_W'(LINE_WORDS - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_MEM_REQ  = 3'd1;
  localparam logic [2:0] S_MEM_WAIT = 3'd2;
  localparam logic [2:0] S_FILL     = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]                  state_q, state_d;
  logic [WI_W-1:0]             beat_q, beat_d;
  logic [31-OFF:0]             tag_q, tag_d;
  logic [WI_W-1:0]             word_q, word_d;
  logic [31:0]                 sdata_q, sdata_d;
  logic [ROB_IDX_W-1:0]        rob_q, rob_d;
  logic                        store_q, store_d;
  logic                        killed_q, killed_d;
  logic [LINE_WORDS-1:0][31:0] buf_q, buf_d;
  logic [LINE_WORDS-1:0][31:0] merged;
  logic                        busy_after_ack;
  logic                        unused_addr_bits;

  // byte offset within a word never matters: refills are whole words
  assign unused_addr_bits = ^bus.repair_req_addr_i[1:0];
  assign busy_after_ack   = (state_q == S_MEM_REQ) || (state_q == S_MEM_WAIT) || (state_q == S_FILL);

  // next-state: request capture, beat sequencing, line buffering and the load-kill flag
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    tag_d    = tag_q;
    word_d   = word_q;
    sdata_d  = sdata_q;
    rob_d    = rob_q;
    store_d  = store_q;
    killed_d = killed_q;
    buf_d    = buf_q;
    if (busy_after_ack && bus.flush_i && !store_q) begin
      killed_d = 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (bus.repair_req_i) begin
          state_d  = S_MEM_REQ;
          beat_d   = '0;
          tag_d    = bus.repair_req_addr_i[31:OFF];
          word_d   = bus.repair_req_addr_i[OFF-1:2];
          sdata_d  = bus.repair_req_data_i;
          rob_d    = bus.repair_req_rob_idx_i;
          store_d  = bus.repair_is_store_i;
          killed_d = bus.flush_i && !bus.repair_is_store_i;
        end
      end
      S_MEM_REQ: begin
        if (bus.mem_gnt_i) begin
          state_d = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        if (bus.mem_rvalid_i) begin
          buf_d[beat_q] = bus.mem_rdata_i;
          if (beat_q == LAST_BEAT) begin
            state_d = S_FILL;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = S_MEM_REQ;
          end
        end
      end
      S_FILL: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d  = S_IDLE;
        killed_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state registers; reset aborts any refill in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      tag_q    <= '0;
      word_q   <= '0;
      sdata_q  <= '0;
      rob_q    <= '0;
      store_q  <= 1'b0;
      killed_q <= 1'b0;
      buf_q    <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      tag_q    <= tag_d;
      word_q   <= word_d;
      sdata_q  <= sdata_d;
      rob_q    <= rob_d;
      store_q  <= store_d;
      killed_q <= killed_d;
      buf_q    <= buf_d;
    end
  end

  // line as written to the cache: a store miss overlays its data on the missed word
  always_comb begin
    merged = buf_q;
    if (store_q) begin
      merged[word_q] = sdata_q;
    end
  end

  assign bus.repair_ack_o      = (state_q == S_IDLE) && bus.repair_req_i && !rst_i;
  assign bus.repair_complete_o = (state_q == S_DONE);
  assign bus.mem_req_o         = (state_q == S_MEM_REQ);
  assign bus.mem_addr_o        = bus.mem_req_o ? {tag_q, beat_q, 2'b00} : 32'd0;
  assign bus.fill_en_o         = (state_q == S_FILL);
  assign bus.fill_addr_o       = bus.fill_en_o ? {tag_q, {OFF{1'b0}}} : 32'd0;
  assign bus.fill_data_o       = bus.fill_en_o ? merged : '0;
  assign bus.fill_dirty_o      = bus.fill_en_o && store_q;
  assign bus.wb_valid_o        = (state_q == S_DONE) && !store_q && !killed_q;
  assign bus.wb_rob_idx_o      = bus.wb_valid_o ? rob_q : '0;
  assign bus.wb_data_o         = bus.wb_valid_o ? buf_q[word_q] : 32'd0;
endmodule

// File: tb/tb_mshr_refill_controller.sv
// tb/tb_mshr_refill_controller.sv - randomized self-checking bench for mshr_refill_controller
module tb_mshr_refill_controller;
  localparam int LW = 4;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mshr_refill_controller_if #(.LINE_WORDS(LW), .ROB_IDX_W(RW)) bus ();
  mshr_refill_controller #(.LINE_WORDS(LW), .ROB_IDX_W(RW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  // observations gathered by the transaction driver
  int ack0, ack_busy, done_cyc, done_cnt, fill_cnt, fill_cyc, wb_cnt, unstable, leaks, exp_done, n_gnt;
  logic [31:0]      fill_addr_obs, wb_data_obs;
  logic [32*LW-1:0] fill_data_obs, addr_obs;
  logic             dirty_obs;
  logic [RW-1:0]    wb_rob_obs;
  logic [31:0]      resp [LW];

  logic [32*LW+2*32+RW+32+5-1:0] all_out;
  assign all_out = {bus.repair_ack_o, bus.repair_complete_o, bus.mem_req_o, bus.mem_addr_o,
                    bus.fill_en_o, bus.fill_addr_o, bus.fill_data_o, bus.fill_dirty_o,
                    bus.wb_valid_o, bus.wb_rob_idx_o, bus.wb_data_o};

  // reference: line word i comes from memory, except the store's word on a store miss
  function automatic logic [32*LW-1:0] exp_line(input logic [31:0] a, input logic [31:0] d, input logic st);
    logic [32*LW-1:0] l;
    int w = int'((a >> 2) % LW);
    for (int i = 0; i < LW; i++) l[32*i +: 32] = (st && i == w) ? d : resp[i];
    return l;
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] a);
    return a - (a % (4 * LW));
  endfunction

  function automatic logic [32*LW-1:0] exp_addrs(input logic [31:0] a);
    logic [32*LW-1:0] v;
    for (int i = 0; i < LW; i++) v[32*i +: 32] = line_base(a) + 32'(4 * i);
    return v;
  endfunction

  task automatic idle_inputs();
    bus.flush_i = 0; bus.repair_req_i = 0; bus.repair_req_addr_i = 0; bus.repair_req_data_i = 0;
    bus.repair_req_rob_idx_i = 0; bus.repair_is_store_i = 0;
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0;
  endtask

  // drives one repair with a responsive memory; stops at the complete pulse or after a cycle budget
  task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic [RW-1:0] r, input logic st,
                         input int gmax, input int rvmax, input int flush_cyc,
                         input int stall_beat, input int stall_len, input bit hold, input bit strays);
    int cyc = 0, gwait = -1, gsel = 0, rv_at = -1, beat = 0, rvd;
    bit prev_wait = 0;
    logic [31:0] prev_addr = 0;
    ack0 = 0; ack_busy = 0; done_cyc = -1; done_cnt = 0; fill_cnt = 0; fill_cyc = -1; wb_cnt = 0;
    unstable = 0; leaks = 0; exp_done = 2; n_gnt = 0; addr_obs = '0;
    fill_addr_obs = 0; fill_data_obs = '0; dirty_obs = 0; wb_rob_obs = 0; wb_data_obs = 0;
    while (cyc < 400) begin
      @(negedge clk);
      bus.repair_req_i = (cyc == 0) || hold;
      bus.repair_req_addr_i = a; bus.repair_req_data_i = d;
      bus.repair_req_rob_idx_i = r; bus.repair_is_store_i = st;
      bus.flush_i = (cyc == flush_cyc);
      bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = $urandom;
      if (rv_at == cyc) begin
        bus.mem_rvalid_i = 1; bus.mem_rdata_i = resp[beat]; beat++; rv_at = -1;
      end else if (strays && rv_at < 0) begin
        bus.mem_rvalid_i = 1;
      end
      if (bus.mem_req_o) begin
        if (gwait < 0) begin
          gwait = (beat == stall_beat) ? stall_len : int'($urandom_range(0, gmax));
          gsel = gwait;
        end
        if (gwait == 0) begin
          bus.mem_gnt_i = 1;
          rvd = int'($urandom_range(1, rvmax));
          rv_at = cyc + rvd;
          exp_done += gsel + rvd + 1;
          gwait = -1;
        end else begin
          gwait--;
        end
      end
      #1;
      if (cyc == 0) ack0 = bus.repair_ack_o;
      else if (bus.repair_ack_o) ack_busy++;
      if (prev_wait && (!bus.mem_req_o || bus.mem_addr_o !== prev_addr)) unstable++;
      prev_wait = bus.mem_req_o && !bus.mem_gnt_i;
      prev_addr = bus.mem_addr_o;
      if (bus.mem_req_o && bus.mem_gnt_i) begin
        if (n_gnt < LW) addr_obs[32*n_gnt +: 32] = bus.mem_addr_o;
        n_gnt++;
      end
      if (bus.fill_en_o) begin
        fill_cnt++; fill_cyc = cyc;
        fill_addr_obs = bus.fill_addr_o; fill_data_obs = bus.fill_data_o; dirty_obs = bus.fill_dirty_o;
      end else if (bus.fill_addr_o != 0 || bus.fill_data_o != 0 || bus.fill_dirty_o) leaks++;
      if (bus.wb_valid_o) begin
        wb_cnt++; wb_rob_obs = bus.wb_rob_idx_o; wb_data_obs = bus.wb_data_o;
      end else if (bus.wb_rob_idx_o != 0 || bus.wb_data_o != 0) leaks++;
      if (bus.repair_complete_o) begin
        done_cnt++; done_cyc = cyc;
        break;
      end
      if (cyc == 0 && !bus.repair_ack_o) break;
      cyc++;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (all_out !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
    @(negedge clk);
    rst = 0;
    #1;
    total++; if (all_out !== '0) begin bad++; $display("FAIL idle_outputs got=%h exp=0", all_out); end
    bus.repair_req_i = 1;
    #1;
    total++; if (bus.repair_ack_o !== 1'b1) begin bad++; $display("FAIL idle_comb_ack got=%b exp=1", bus.repair_ack_o); end
    bus.repair_req_i = 0;
  endtask

  task automatic test_load_basic();
    for (int i = 0; i < LW; i++) resp[i] = 32'hA0 + 32'(i);
    run_txn(32'h0000_1008, 32'h0, 5'd5, 1'b0, 0, 1, -1, -1, 0, 0, 0);
    total++; if (ack0 !== 1) begin bad++; $display("FAIL load_ack got=%0d exp=1", ack0); end
    total++; if (addr_obs !== exp_addrs(32'h1008) || n_gnt != LW) begin bad++; $display("FAIL load_mem_addrs got=%h n=%0d exp=%h", addr_obs, n_gnt, exp_addrs(32'h1008)); end
    total++; if ({fill_cnt, fill_addr_obs, dirty_obs} !== {32'd1, 32'h1000, 1'b0}) begin bad++; $display("FAIL load_fill got=%0d/%h/%b exp=1/1000/0", fill_cnt, fill_addr_obs, dirty_obs); end
    total++; if (fill_data_obs !== {32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin bad++; $display("FAIL load_fill_data got=%h", fill_data_obs); end
    total++; if ({wb_cnt, wb_rob_obs, wb_data_obs} !== {32'd1, 5'd5, 32'hA2}) begin bad++; $display("FAIL load_wb got=%0d/%0d/%h exp=1/5/a2", wb_cnt, wb_rob_obs, wb_data_obs); end
    total++; if (done_cyc != 10 || done_cnt != 1 || fill_cyc != 9) begin bad++; $display("FAIL load_latency got=%0d fill=%0d exp=10 fill=9", done_cyc, fill_cyc); end
    total++; if (leaks != 0 || ack_busy != 0) begin bad++; $display("FAIL load_idle_zero got leaks=%0d acks=%0d exp=0", leaks, ack_busy); end
  endtask

  task automatic test_store();
    for (int i = 0; i < LW; i++) resp[i] = 32'hB0 + 32'(i);
    run_txn(32'h0000_2004, 32'hDEAD_BEEF, 5'd9, 1'b1, 0, 1, -1, -1, 0, 0, 0);
    total++; if (fill_data_obs !== {32'hB3, 32'hB2, 32'hDEAD_BEEF, 32'hB0}) begin bad++; $display("FAIL store_fill_data got=%h", fill_data_obs); end
    total++; if ({fill_cnt, fill_addr_obs, dirty_obs} !== {32'd1, 32'h2000, 1'b1}) begin bad++; $display("FAIL store_fill got=%0d/%h/%b exp=1/2000/1", fill_cnt, fill_addr_obs, dirty_obs); end
    total++; if (wb_cnt != 0 || done_cnt != 1) begin bad++; $display("FAIL store_wb_complete got wb=%0d done=%0d exp=0/1", wb_cnt, done_cnt); end
  endtask

  task automatic test_gnt_stall();
    for (int i = 0; i < LW; i++) resp[i] = $urandom;
    run_txn(32'h0000_30F4, 32'h0, 5'd17, 1'b0, 0, 1, -1, 2, 5, 0, 1);
    total++; if (unstable != 0) begin bad++; $display("FAIL stall_req_stable got=%0d exp=0", unstable); end
    total++; if (fill_data_obs !== exp_line(32'h30F4, 0, 0) || addr_obs !== exp_addrs(32'h30F4)) begin bad++; $display("FAIL stall_line got=%h exp=%h", fill_data_obs, exp_line(32'h30F4, 0, 0)); end
    total++; if (done_cyc != 15 || wb_data_obs !== resp[1]) begin bad++; $display("FAIL stall_done got=%0d/%h exp=15/%h", done_cyc, wb_data_obs, resp[1]); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < LW; i++) resp[i] = 32'hC0 + 32'(i);
    run_txn(32'h0000_500C, 32'h0, 5'd7, 1'b0, 0, 1, 3, -1, 0, 0, 0);
    total++; if ({fill_cnt, done_cnt, wb_cnt} !== {32'd1, 32'd1, 32'd0}) begin bad++; $display("FAIL flush_kill got fill=%0d done=%0d wb=%0d exp=1/1/0", fill_cnt, done_cnt, wb_cnt); end
    run_txn(32'h0000_6000, 32'h0, 5'd8, 1'b0, 0, 1, -1, -1, 0, 0, 0);
    total++; if ({ack0, wb_cnt, wb_rob_obs, wb_data_obs} !== {32'd1, 32'd1, 5'd8, 32'hC0}) begin bad++; $display("FAIL flush_next_load got=%0d/%0d/%0d/%h exp=1/1/8/c0", ack0, wb_cnt, wb_rob_obs, wb_data_obs); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < LW; i++) resp[i] = 32'hD0 + 32'(i);
    run_txn(32'h0000_7004, 32'h0, 5'd11, 1'b0, 1, 2, -1, -1, 0, 1, 0);
    total++; if (ack0 != 1 || ack_busy != 0 || wb_data_obs !== 32'hD1) begin bad++; $display("FAIL b2b_first got ack=%0d busy=%0d wb=%h exp=1/0/d1", ack0, ack_busy, wb_data_obs); end
    run_txn(32'h0000_800C, 32'h0, 5'd12, 1'b0, 1, 2, -1, -1, 0, 1, 0);
    total++; if (ack0 != 1 || ack_busy != 0 || wb_data_obs !== 32'hD3 || wb_rob_obs !== 5'd12) begin bad++; $display("FAIL b2b_second got ack=%0d busy=%0d wb=%h exp=1/0/d3", ack0, ack_busy, wb_data_obs); end
    @(negedge clk);
    bus.repair_req_i = 0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < LW; i++) resp[i] = 32'hE0 + 32'(i);
    @(negedge clk);
    bus.repair_req_i = 1; bus.repair_req_addr_i = 32'h4010; bus.repair_is_store_i = 0; bus.repair_req_rob_idx_i = 3;
    @(negedge clk);
    bus.repair_req_i = 0; bus.mem_gnt_i = 1;
    #1;
    total++; if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h4010) begin bad++; $display("FAIL arst_pre_req got=%b/%h exp=1/4010", bus.mem_req_o, bus.mem_addr_o); end
    @(negedge clk);
    bus.mem_gnt_i = 0;
    #2 rst = 1;
    #1;
    total++; if (all_out !== '0) begin bad++; $display("FAIL arst_immediate got=%h exp=0", all_out); end
    @(negedge clk);
    bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hBAD0_0001;
    @(negedge clk);
    rst = 0;
    #1;
    total++; if (all_out !== '0) begin bad++; $display("FAIL arst_late_rvalid got=%h exp=0", all_out); end
    @(negedge clk);
    bus.mem_rvalid_i = 0;
    run_txn(32'h0000_4010, 32'h0, 5'd3, 1'b0, 0, 1, -1, -1, 0, 0, 0);
    total++; if ({ack0, done_cyc, wb_data_obs} !== {32'd1, 32'd10, 32'hE0}) begin bad++; $display("FAIL arst_recover got=%0d/%0d/%h exp=1/10/e0", ack0, done_cyc, wb_data_obs); end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic st;
    logic [RW-1:0] r;
    int fc;
    bit exp_wb;
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < LW; i++) resp[i] = $urandom;
      a = $urandom; d = $urandom; st = 1'($urandom_range(0, 1)); r = RW'($urandom);
      fc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 2 * LW)) : -1;
      exp_wb = !st && fc < 0;
      run_txn(a, d, r, st, 3, 3, fc, -1, 0, 0, 1'($urandom_range(0, 1)));
      total++; if (fill_data_obs !== exp_line(a, d, st) || fill_addr_obs !== line_base(a) || dirty_obs !== st) begin bad++; $display("FAIL rand_fill[%0d] got=%h exp=%h", n, fill_data_obs, exp_line(a, d, st)); end
      total++; if (addr_obs !== exp_addrs(a) || n_gnt != LW || unstable != 0) begin bad++; $display("FAIL rand_mem[%0d] got=%h n=%0d exp=%h", n, addr_obs, n_gnt, exp_addrs(a)); end
      total++; if (wb_cnt != int'(exp_wb) || (exp_wb && ({wb_rob_obs, wb_data_obs} !== {r, resp[(a >> 2) % LW]}))) begin bad++; $display("FAIL rand_wb[%0d] got=%0d/%0d/%h exp=%0d", n, wb_cnt, wb_rob_obs, wb_data_obs, exp_wb); end
      total++; if (done_cyc != exp_done || done_cnt != 1 || fill_cyc != exp_done - 1 || leaks != 0) begin bad++; $display("FAIL rand_done[%0d] got=%0d exp=%0d", n, done_cyc, exp_done); end
    end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_store();
    test_gnt_stall();
    test_flush();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
